// File: rtl/sram_pkg.sv
// Shared helpers for the multi-port SRAM front end: address/port-id widths and pipeline control fields.
package sram_pkg;

  localparam int unsigned SRAM_MAX_PORT = 8;
  localparam int unsigned SRAM_MAX_LAT  = 4;

  function automatic int unsigned sram_clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned sram_aw(input int unsigned word_depth);
    return sram_clog2_min1(word_depth);
  endfunction

  function automatic int unsigned sram_pw(input int unsigned num_port);
    return sram_clog2_min1(num_port);
  endfunction

  // Width-independent part of a pipeline entry; pid/data widths are added by the top level.
  typedef struct packed {
    logic valid;
    logic wen;
    logic err;
  } sram_pipe_ctl_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, with wrap; owns the pointer.
module sram_rr_arb
  import sram_pkg::*;
#(
  parameter int unsigned NUM_PORT = 2,
  localparam int unsigned PW = sram_pw(NUM_PORT)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_PORT-1:0] req_i,
  input  logic                accept_i,
  output logic [NUM_PORT-1:0] grant_o,
  output logic [PW-1:0]       grant_idx_o
);

  logic [PW-1:0] ptr_q;
  logic          found;

  // Search order i = 0..N-1 visits port (ptr+i) mod N; constant port indices keep selects narrow.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      for (int unsigned p = 0; p < NUM_PORT; p++) begin
        if (!found && req_i[p] && (((32'(ptr_q) + i) % NUM_PORT) == p)) begin
          found       = 1'b1;
          grant_o[p]  = 1'b1;
          grant_idx_o = PW'(p);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else if (accept_i) begin
      ptr_q <= PW'((32'(grant_idx_o) + 1) % NUM_PORT);
    end
  end

endmodule

// File: rtl/sram_mport_ctrl.sv
// Multi-requester SRAM front end: RR arbitration, byte-masked array, fixed-latency response pipeline.
// Optional SRAM_ERR_EN: out-of-range addresses are accepted without array write and flagged on rsp_err_o.
module sram_mport_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned NUM_PORT   = 2,
  parameter int unsigned BIT_WIDTH  = 64,
  parameter int unsigned WORD_DEPTH = 512,
  parameter int unsigned RD_LAT     = 1,
  localparam int unsigned AW  = sram_aw(WORD_DEPTH),
  localparam int unsigned PW  = sram_pw(NUM_PORT),
  localparam int unsigned BW8 = BIT_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_PORT-1:0]           req_valid_i,
  output logic [NUM_PORT-1:0]           req_ready_o,
  input  logic [NUM_PORT-1:0]           req_wen_i,
  input  logic [NUM_PORT*BW8-1:0]       req_bm_i,
  input  logic [NUM_PORT*AW-1:0]        req_addr_i,
  input  logic [NUM_PORT*BIT_WIDTH-1:0] req_dat_i,
  output logic [NUM_PORT-1:0]           rsp_valid_o,
  output logic [BIT_WIDTH-1:0]          rsp_dat_o,
  output logic                          rsp_err_o
);

  typedef struct packed {
    sram_pipe_ctl_t       ctl;
    logic [PW-1:0]        pid;
    logic [BIT_WIDTH-1:0] dat;
  } sram_pipe_t;

  logic [NUM_PORT-1:0]  grant;
  logic [PW-1:0]        grant_idx;
  logic                 accept;

  logic                 sel_wen;
  logic [BW8-1:0]       sel_bm;
  logic [AW-1:0]        sel_addr;
  logic [BIT_WIDTH-1:0] sel_dat;
  logic                 in_range;
  logic [BIT_WIDTH-1:0] rd_word;

  logic [BIT_WIDTH-1:0] mem [WORD_DEPTH];

  sram_pipe_t           pipe_in;
  sram_pipe_t           pipe_q [RD_LAT];
  sram_pipe_t           pipe_out;

  sram_rr_arb #(
    .NUM_PORT (NUM_PORT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_valid_i),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Grant is only ever raised for a valid port, so any grant is an accept.
  assign req_ready_o = grant;
  assign accept      = |grant;

  always_comb begin
    sel_wen  = 1'b0;
    sel_bm   = '0;
    sel_addr = '0;
    sel_dat  = '0;
    for (int unsigned p = 0; p < NUM_PORT; p++) begin
      if (grant[p]) begin
        sel_wen  = req_wen_i[p];
        sel_bm   = req_bm_i[p*BW8 +: BW8];
        sel_addr = req_addr_i[p*AW +: AW];
        sel_dat  = req_dat_i[p*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

`ifdef SRAM_ERR_EN
  assign in_range = (32'(sel_addr) < WORD_DEPTH);
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (accept && sel_wen && in_range) begin
      for (int unsigned b = 0; b < BW8; b++) begin
        if (sel_bm[b]) begin
          mem[sel_addr][b*8 +: 8] <= sel_dat[b*8 +: 8];
        end
      end
    end
  end

  assign rd_word = mem[sel_addr];

  always_comb begin
    pipe_in = '0;
    if (accept) begin
      pipe_in.ctl.valid = 1'b1;
      pipe_in.ctl.wen   = sel_wen;
      pipe_in.ctl.err   = ~in_range;
      pipe_in.pid       = grant_idx;
      pipe_in.dat       = rd_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign pipe_out = pipe_q[RD_LAT-1];

  // Raw array word travels down the pipe; write and error responses are zeroed only at the output.
  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned p = 0; p < NUM_PORT; p++) begin
      rsp_valid_o[p] = pipe_out.ctl.valid && (pipe_out.pid == PW'(p));
    end
    rsp_dat_o = '0;
    if (pipe_out.ctl.valid && !pipe_out.ctl.wen && !pipe_out.ctl.err) begin
      rsp_dat_o = pipe_out.dat;
    end
    rsp_err_o = pipe_out.ctl.valid && pipe_out.ctl.err;
  end

endmodule

// File: tb/tb_sram_mport_ctrl.sv
// Directed bench for sram_mport_ctrl: four instances (RD_LAT 1..4) share stimulus; exact latency is checked per instance.
module tb_sram_mport_ctrl;

  localparam logic [63:0] D1  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D9  = 64'hA5A5_0F0F_1234_5678;
  localparam logic [63:0] DFF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_wen;
  logic [15:0]  req_bm;
  logic [17:0]  req_addr;
  logic [127:0] req_dat;

  logic [1:0]   ready_w [4];
  logic [1:0]   rv_w    [4];
  logic [63:0]  rd_w    [4];
  logic         err_w   [4];

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]   s_valid [8];
  logic [1:0]   s_wen   [8];
  logic [15:0]  s_bm    [8];
  logic [17:0]  s_addr  [8];
  logic [127:0] s_dat   [8];
  logic [1:0]   e_ready [8];
  logic [63:0]  e_dat   [8];
  logic         e_err   [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_mport_ctrl #(
      .NUM_PORT   (2),
      .BIT_WIDTH  (64),
      .WORD_DEPTH (500),
      .RD_LAT     (g + 1)
    ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (ready_w[g]),
      .req_wen_i   (req_wen),
      .req_bm_i    (req_bm),
      .req_addr_i  (req_addr),
      .req_dat_i   (req_dat),
      .rsp_valid_o (rv_w[g]),
      .rsp_dat_o   (rd_w[g]),
      .rsp_err_o   (err_w[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 8; i++) begin
      s_valid[i] = '0; s_wen[i] = '0; s_bm[i] = '0; s_addr[i] = '0; s_dat[i] = '0;
      e_ready[i] = '0; e_dat[i] = '0; e_err[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input int p, input logic wen, input logic [8:0] addr,
                         input logic [7:0] bm, input logic [63:0] dat);
    s_valid[i][p]       = 1'b1;
    s_wen[i][p]         = wen;
    s_bm[i][p*8 +: 8]   = bm;
    s_addr[i][p*9 +: 9] = addr;
    s_dat[i][p*64 +: 64] = dat;
  endtask

  task automatic set_exp(input int i, input logic [1:0] rdy, input logic [63:0] dat, input logic err);
    e_ready[i] = rdy;
    e_dat[i]   = dat;
    e_err[i]   = err;
  endtask

  task automatic drive_idle();
    req_valid = '0; req_wen = '0; req_bm = '0; req_addr = '0; req_dat = '0;
  endtask

  // Step t drives at negedge t; an instance with latency L shows step j's response at negedge j+L.
  task automatic run(input string name, input int n, input int tail);
    for (int t = 0; t < n + tail; t++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        int j;
        j = t - (g + 1);
        if (j >= 0 && j < n) begin
          chk($sformatf("%s rsp_valid L%0d t%0d", name, g + 1, t), 128'(rv_w[g]), 128'(e_ready[j]));
          if (e_ready[j] != 2'b00) begin
            chk($sformatf("%s rsp_dat L%0d t%0d", name, g + 1, t), 128'(rd_w[g]), 128'(e_dat[j]));
            chk($sformatf("%s rsp_err L%0d t%0d", name, g + 1, t), 128'(err_w[g]), 128'(e_err[j]));
          end
        end else begin
          chk($sformatf("%s rsp_idle L%0d t%0d", name, g + 1, t), 128'(rv_w[g]), 128'(0));
        end
      end
      if (t < n) begin
        req_valid = s_valid[t]; req_wen = s_wen[t]; req_bm = s_bm[t];
        req_addr = s_addr[t]; req_dat = s_dat[t];
      end else begin
        drive_idle();
      end
      #1;
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("%s ready L%0d t%0d", name, g + 1, t), 128'(ready_w[g]),
            128'((t < n) ? e_ready[t] : 2'b00));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    clr();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset ready L%0d", g + 1), 128'(ready_w[g]), 128'(0));
      chk($sformatf("reset rsp_valid L%0d", g + 1), 128'(rv_w[g]), 128'(0));
      chk($sformatf("reset rsp_dat L%0d", g + 1), 128'(rd_w[g]), 128'(0));
      chk($sformatf("reset rsp_err L%0d", g + 1), 128'(err_w[g]), 128'(0));
    end
    rst_n = 1'b1;

    // Full-word write then immediate read of the same address.
    clr();
    set_req(0, 0, 1'b1, 9'd5, 8'hFF, D1); set_exp(0, 2'b01, 64'h0, 1'b0);
    set_req(1, 0, 1'b0, 9'd5, 8'h00, 64'h0); set_exp(1, 2'b01, D1, 1'b0);
    run("wr_rd", 2, 5);

    // Partial byte mask.
    clr();
    set_req(0, 0, 1'b1, 9'd7, 8'hFF, DFF); set_exp(0, 2'b01, 64'h0, 1'b0);
    set_req(1, 0, 1'b1, 9'd7, 8'h0F, 64'h0); set_exp(1, 2'b01, 64'h0, 1'b0);
    set_req(2, 0, 1'b0, 9'd7, 8'h00, 64'h0); set_exp(2, 2'b01, 64'hFFFF_FFFF_0000_0000, 1'b0);
    run("mask", 3, 5);

    // Read on the other port right after a write to the same address.
    clr();
    set_req(0, 0, 1'b1, 9'd9, 8'hFF, D9); set_exp(0, 2'b01, 64'h0, 1'b0);
    set_req(1, 1, 1'b0, 9'd9, 8'h00, 64'h0); set_exp(1, 2'b10, D9, 1'b0);
    run("raw", 2, 5);

    // Both ports request for four cycles: grants alternate.
    clr();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 0, 1'b0, 9'd5, 8'h00, 64'h0);
      set_req(i, 1, 1'b0, 9'd9, 8'h00, 64'h0);
    end
    set_exp(0, 2'b01, D1, 1'b0); set_exp(1, 2'b10, D9, 1'b0);
    set_exp(2, 2'b01, D1, 1'b0); set_exp(3, 2'b10, D9, 1'b0);
    run("rr", 4, 5);

    // Reset while three reads are in flight.
    clr();
    set_req(0, 0, 1'b0, 9'd5, 8'h00, 64'h0); set_exp(0, 2'b01, D1, 1'b0);
    set_req(1, 0, 1'b0, 9'd7, 8'h00, 64'h0); set_exp(1, 2'b01, 64'hFFFF_FFFF_0000_0000, 1'b0);
    set_req(2, 0, 1'b0, 9'd9, 8'h00, 64'h0); set_exp(2, 2'b01, D9, 1'b0);
    run("pre_rst", 3, 0);
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("midrst rsp_valid L%0d", g + 1), 128'(rv_w[g]), 128'(0));
      chk($sformatf("midrst rsp_err L%0d", g + 1), 128'(err_w[g]), 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    run("post_rst", 0, 6);
    clr();
    set_req(0, 0, 1'b0, 9'd5, 8'h00, 64'h0); set_req(0, 1, 1'b0, 9'd9, 8'h00, 64'h0);
    set_exp(0, 2'b01, D1, 1'b0);
    set_req(1, 1, 1'b0, 9'd9, 8'h00, 64'h0); set_exp(1, 2'b10, D9, 1'b0);
    run("ptr_keep", 2, 5);

`ifdef SRAM_ERR_EN
    clr();
    set_req(0, 0, 1'b1, 9'd500, 8'hFF, DFF); set_exp(0, 2'b01, 64'h0, 1'b1);
    set_req(1, 1, 1'b0, 9'd500, 8'h00, 64'h0); set_exp(1, 2'b10, 64'h0, 1'b1);
    set_req(2, 0, 1'b0, 9'd5, 8'h00, 64'h0); set_exp(2, 2'b01, D1, 1'b0);
    set_req(3, 1, 1'b0, 9'd9, 8'h00, 64'h0); set_exp(3, 2'b10, D9, 1'b0);
    run("err", 4, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
